// File: rtl/icefun_led_framebuffer.sv
// Double-buffered 4x8 LED column framebuffer with a CPU register interface.
// SHADOW is written by software; ACTIVE drives the LED columns and is only
// updated from SHADOW on a frame boundary, so a scan never shows a torn frame.
module icefun_led_framebuffer (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic [7:0]  leds1,
  output logic [7:0]  leds2,
  output logic [7:0]  leds3,
  output logic [7:0]  leds4
);

  typedef enum logic [1:0] {
    REG_SHADOW = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_ACTIVE = 2'd3
  } reg_e;

  logic [31:0] shadow_q, shadow_d;
  logic [31:0] active_q, active_d;
  logic        autoswap_q, autoswap_d;
  logic        blink_en_q, blink_en_d;
  logic [7:0]  period_q, period_d;
  logic        pending_q, pending_d;
  logic        blank_q, blank_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic [11:0] scan_q, scan_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] leds_q, leds_d;

  logic        accept;
  logic        frame_tick;
  logic        set_pending;
  logic [7:0]  blink_limit;
  logic [8:0]  blink_next;
  reg_e        word_sel;
  logic        unused_addr;

  assign unused_addr = ^bus_addr[1:0];

  // Next-state logic: bus handshake, register writes, swap, blink and scan.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    autoswap_d  = autoswap_q;
    blink_en_d  = blink_en_q;
    period_d    = period_q;
    pending_d   = pending_q;
    blank_d     = blank_q;
    blink_cnt_d = blink_cnt_q;
    frame_cnt_d = frame_cnt_q;
    set_pending = 1'b0;
    word_sel    = reg_e'(bus_addr[3:2]);

    accept     = bus_valid && !ready_q;
    frame_tick = (scan_q == '1);
    scan_d     = scan_q + 12'd1;
    if (frame_tick) frame_cnt_d = frame_cnt_q + 8'd1;

    ready_d = accept;
    rdata_d = '0;
    if (accept && !bus_we) begin
      case (word_sel)
        REG_SHADOW: rdata_d = shadow_q;
        REG_CTRL:   rdata_d = {16'h0, period_q, 6'h0, blink_en_q, autoswap_q};
        REG_STATUS: rdata_d = {16'h0, frame_cnt_q, 6'h0, blank_q, pending_q};
        default:    rdata_d = active_q;
      endcase
    end

    // Swap uses pre-write SHADOW; a request arriving on the same edge re-arms
    // pending after the clear, deferring it to the following tick.
    if (frame_tick && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (accept && bus_we) begin
      case (word_sel)
        REG_SHADOW: begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (bus_wstrb[i]) shadow_d[8*i +: 8] = bus_wdata[8*i +: 8];
          end
          if (autoswap_q) set_pending = 1'b1;
        end
        REG_CTRL: begin
          if (bus_wstrb[0]) begin
            autoswap_d = bus_wdata[0];
            blink_en_d = bus_wdata[1];
            if (bus_wdata[2]) set_pending = 1'b1;
          end
          if (bus_wstrb[1]) period_d = bus_wdata[15:8];
        end
        default: ;
      endcase
    end
    if (set_pending) pending_d = 1'b1;

    blink_limit = (period_q == '0) ? 8'd1 : period_q;
    blink_next  = {1'b0, blink_cnt_q} + 9'd1;
    if (!blink_en_q) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (frame_tick) begin
      if (blink_next >= {1'b0, blink_limit}) begin
        blink_cnt_d = '0;
        blank_d     = !blank_q;
      end else begin
        blink_cnt_d = blink_next[7:0];
      end
    end

    leds_d = blank_q ? '0 : active_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      shadow_q    <= '0;
      active_q    <= '0;
      autoswap_q  <= 1'b0;
      blink_en_q  <= 1'b0;
      period_q    <= '0;
      pending_q   <= 1'b0;
      blank_q     <= 1'b0;
      blink_cnt_q <= '0;
      scan_q      <= '0;
      frame_cnt_q <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      leds_q      <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      autoswap_q  <= autoswap_d;
      blink_en_q  <= blink_en_d;
      period_q    <= period_d;
      pending_q   <= pending_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      scan_q      <= scan_d;
      frame_cnt_q <= frame_cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      leds_q      <= leds_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign leds1     = leds_q[7:0];
  assign leds2     = leds_q[15:8];
  assign leds3     = leds_q[23:16];
  assign leds4     = leds_q[31:24];

endmodule

// File: tb/tb_icefun_led_framebuffer.sv
// Self-checking bench for icefun_led_framebuffer: a frame-level reference
// model is compared against the DUT every cycle, plus directed literal checks.
module tb_icefun_led_framebuffer;

  logic        clk12MHz;
  logic        rst;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic [7:0]  leds1, leds2, leds3, leds4;

  icefun_led_framebuffer dut (
    .clk12MHz (clk12MHz),
    .rst      (rst),
    .bus_valid(bus_valid),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready),
    .bus_rdata(bus_rdata),
    .leds1    (leds1),
    .leds2    (leds2),
    .leds3    (leds3),
    .leds4    (leds4)
  );

  initial begin
    clk12MHz = 1'b0;
    forever #5 clk12MHz = ~clk12MHz;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [31:0] m_shadow, m_active, m_rdata, m_leds;
  logic        m_auto, m_blinken, m_pending, m_blank, m_ready;
  logic [7:0]  m_period;
  int          m_bcnt, m_scan, m_frames;
  logic        m_tick, m_acc;

  function automatic logic [31:0] m_read(input logic [1:0] w);
    case (w)
      2'd0:    return m_shadow;
      2'd1:    return {16'h0, m_period, 6'h0, m_blinken, m_auto};
      2'd2:    return {16'h0, 8'(m_frames), 6'h0, m_blank, m_pending};
      default: return m_active;
    endcase
  endfunction

  always @(posedge clk12MHz) begin
    if (rst) begin
      m_shadow = 0; m_active = 0; m_rdata = 0; m_leds = 0;
      m_auto = 0; m_blinken = 0; m_pending = 0; m_blank = 0; m_ready = 0;
      m_period = 0; m_bcnt = 0; m_scan = 0; m_frames = 0;
    end else begin
      m_tick  = (m_scan == 4095);
      m_acc   = bus_valid && !m_ready;
      m_leds  = m_blank ? 32'h0 : m_active;
      m_rdata = (m_acc && !bus_we) ? m_read(bus_addr[3:2]) : 32'h0;
      m_ready = m_acc;
      if (m_tick && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (!m_blinken) begin
        m_bcnt = 0; m_blank = 0;
      end else if (m_tick) begin
        m_bcnt++;
        if (m_bcnt >= ((m_period == 0) ? 1 : int'(m_period))) begin
          m_bcnt = 0; m_blank = !m_blank;
        end
      end
      if (m_tick) m_frames = (m_frames + 1) % 256;
      m_scan = (m_scan + 1) % 4096;
      if (m_acc && bus_we) begin
        if (bus_addr[3:2] == 2'd0) begin
          for (int b = 0; b < 4; b++)
            if (bus_wstrb[b]) m_shadow[8*b +: 8] = bus_wdata[8*b +: 8];
          if (m_auto) m_pending = 1;
        end else if (bus_addr[3:2] == 2'd1) begin
          if (bus_wstrb[0]) begin
            m_auto = bus_wdata[0]; m_blinken = bus_wdata[1];
            if (bus_wdata[2]) m_pending = 1;
          end
          if (bus_wstrb[1]) m_period = bus_wdata[15:8];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk12MHz) begin
    if (started) begin
      check("ready", {31'h0, bus_ready}, {31'h0, m_ready});
      check("rdata", bus_rdata, m_rdata);
      check("leds", {leds4, leds3, leds2, leds1}, m_leds);
    end
  end

  // Issue one bus transfer; called at a negedge, returns at a negedge.
  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd);
    bit got = 0;
    bus_valid = 1; bus_we = we; bus_addr = addr; bus_wdata = wd; bus_wstrb = ws;
    rd = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk12MHz);
      if (bus_ready) begin
        rd = bus_rdata; got = 1;
      end
    end
    if (!got) check("ready_timeout", 32'h0, 32'h1);
    bus_valid = 0; bus_we = 0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] dummy;
    bus_xfer(1'b1, addr, wd, ws, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr,
                        input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, addr, 32'h0, 4'h0, v);
    check(name, v & mask, exp);
  endtask

  task automatic wait_scan(input int v);
    int n = 0;
    while (m_scan != v && n < 5000) begin
      @(negedge clk12MHz);
      n++;
    end
    if (m_scan != v) check("scan_timeout", 32'h0, 32'h1);
  endtask

  task automatic two_cycles();
    @(negedge clk12MHz);
    @(negedge clk12MHz);
  endtask

  int pulses;

  initial begin
    rst = 1; bus_valid = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; bus_wstrb = 0;
    repeat (3) @(negedge clk12MHz);
    started = 1;
    check("rst_leds", {leds4, leds3, leds2, leds1}, 32'h0);
    check("rst_ready", {31'h0, bus_ready}, 32'h0);
    rst = 0;
    @(negedge clk12MHz);

    // Swap request: LEDs hold until the frame boundary
    wr(4'h0, 32'h44332211, 4'hF);
    wr(4'h4, 32'h00000004, 4'hF);
    wait_scan(4095);
    check("pre_swap_leds", {leds4, leds3, leds2, leds1}, 32'h0);
    two_cycles();
    check("leds1", {24'h0, leds1}, 32'h11);
    check("leds2", {24'h0, leds2}, 32'h22);
    check("leds3", {24'h0, leds3}, 32'h33);
    check("leds4", {24'h0, leds4}, 32'h44);
    rd_chk("status_pending_clr", 4'h8, 32'h1, 32'h0);
    rd_chk("status_frames", 4'h8, 32'hFF00, 32'h0100);

    // Byte strobes
    wr(4'h0, 32'hFFFFFFFF, 4'hF);
    wr(4'h0, 32'h0000AB00, 4'b0010);
    rd_chk("shadow_strb", 4'h0, 32'hFFFFFFFF, 32'hFFFFABFF);
    rd_chk("active_kept", 4'hC, 32'hFFFFFFFF, 32'h44332211);
    rd_chk("ctrl_swapreq_reads0", 4'h4, 32'hFFFFFFFF, 32'h0);

    // SHADOW write landing exactly on the frame tick
    wait_scan(4000);
    wr(4'h0, 32'hA1A2A3A4, 4'hF);
    wr(4'h4, 32'h00000004, 4'hF);
    wait_scan(4095);
    wr(4'h0, 32'hB1B2B3B4, 4'hF);
    rd_chk("tick_wr_active", 4'hC, 32'hFFFFFFFF, 32'hA1A2A3A4);
    rd_chk("tick_wr_shadow", 4'h0, 32'hFFFFFFFF, 32'hB1B2B3B4);
    rd_chk("tick_wr_pending", 4'h8, 32'h1, 32'h0);
    // swap_req landing on the tick is deferred one frame
    wait_scan(4095);
    wr(4'h4, 32'h00000004, 4'hF);
    rd_chk("defer_active", 4'hC, 32'hFFFFFFFF, 32'hA1A2A3A4);
    rd_chk("defer_pending", 4'h8, 32'h1, 32'h1);
    wait_scan(4095);
    @(negedge clk12MHz);
    rd_chk("deferred_swap", 4'hC, 32'hFFFFFFFF, 32'hB1B2B3B4);

    // Blink with period 1
    wr(4'h0, 32'h0F0F0F0F, 4'hF);
    wr(4'h4, 32'h00000004, 4'hF);
    wait_scan(4095);
    two_cycles();
    check("blink_start", {leds4, leds3, leds2, leds1}, 32'h0F0F0F0F);
    wr(4'h4, 32'h00000102, 4'hF);
    wait_scan(4095);
    two_cycles();
    check("blink_off1", {leds4, leds3, leds2, leds1}, 32'h0);
    rd_chk("blank_phase", 4'h8, 32'h2, 32'h2);
    wait_scan(4095);
    two_cycles();
    check("blink_on", {leds4, leds3, leds2, leds1}, 32'h0F0F0F0F);
    wait_scan(4095);
    two_cycles();
    check("blink_off2", {leds4, leds3, leds2, leds1}, 32'h0);
    wr(4'h4, 32'h00000000, 4'hF);
    two_cycles();
    check("blink_disable", {leds4, leds3, leds2, leds1}, 32'h0F0F0F0F);

    // Held request: one ready pulse every two cycles
    pulses = 0;
    bus_valid = 1; bus_we = 0; bus_addr = 4'hC;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk12MHz);
      if (bus_ready) begin
        pulses++;
        check("held_rdata", bus_rdata, 32'h0F0F0F0F);
      end
    end
    bus_valid = 0;
    check("held_pulses", pulses, 32'd5);
    rd_chk("addr_lowbits", 4'h3, 32'hFFFFFFFF, 32'h0F0F0F0F);
    wr(4'h8, 32'hFFFFFFFF, 4'hF);
    wr(4'hC, 32'h12121212, 4'hF);
    rd_chk("ro_active", 4'hC, 32'hFFFFFFFF, 32'h0F0F0F0F);
    rd_chk("ro_status", 4'h8, 32'h3, 32'h0);

    // Autoswap arms pending on SHADOW write
    wr(4'h4, 32'h00000001, 4'hF);
    wr(4'h0, 32'h12345678, 4'hF);
    rd_chk("autoswap_pending", 4'h8, 32'h1, 32'h1);

    // Reset during a request with a swap pending
    bus_valid = 1; bus_we = 0; bus_addr = 4'h8; rst = 1;
    two_cycles();
    check("rst_mid_leds", {leds4, leds3, leds2, leds1}, 32'h0);
    check("rst_mid_ready", {31'h0, bus_ready}, 32'h0);
    check("rst_mid_rdata", bus_rdata, 32'h0);
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 4 && pulses == 0; i++) begin
      @(negedge clk12MHz);
      if (bus_ready) begin
        pulses = 1;
        check("post_rst_status", bus_rdata, 32'h0);
      end
    end
    bus_valid = 0;
    check("post_rst_served", pulses, 32'd1);
    wait_scan(4095);
    two_cycles();
    check("no_swap_after_rst", {leds4, leds3, leds2, leds1}, 32'h0);
    rd_chk("active_after_rst", 4'hC, 32'hFFFFFFFF, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
